// File: rtl/jogo_unidade_controle_rodadas_if.sv
// Handshake/bus bundle between the game top level and the round-based control unit.
interface jogo_unidade_controle_rodadas_if #(
  parameter int ADDR_W = 4
) ();
  logic              iniciar;
  logic              jogada;
  logic              igual;
  logic [ADDR_W-1:0] limite;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] rodada;
  logic              zeraR;
  logic              registraR;
  logic              acertou;
  logic              errou;
  logic              timeout;
  logic              pronto;
  logic [3:0]        db_estado;

  modport slave (
    input  iniciar, jogada, igual, limite,
    output endereco, rodada, zeraR, registraR, acertou, errou, timeout, pronto, db_estado
  );

  modport master (
    output iniciar, jogada, igual, limite,
    input  endereco, rodada, zeraR, registraR, acertou, errou, timeout, pronto, db_estado
  );
endinterface

// File: rtl/jogo_unidade_controle_rodadas.sv
// Round-based memory-game control unit: round r checks plays 0..r, game ends after round limite.
// Optional play timeout in espera_jogada is built only when UC_TIMEOUT_EN is defined.
module jogo_unidade_controle_rodadas #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 5000
) (
  input logic                            clock,
  input logic                            reset,
  jogo_unidade_controle_rodadas_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    NOVA_RODADA    = 4'h2,
    ESPERA_JOGADA  = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    PROXIMA_RODADA = 4'h8,
    FIM_ACERTOS    = 4'hC,
`ifdef UC_TIMEOUT_EN
    FIM_TIMEOUT    = 4'hD,
`endif
    FIM_ERRO       = 4'hE
  } estado_t;

  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] UM_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

  estado_t           estado_r;
  estado_t           estado_nxt_s;
  logic [ADDR_W-1:0] endereco_r;
  logic [ADDR_W-1:0] rodada_r;
  logic [ADDR_W-1:0] limite_r;
  logic              zerar_r;
  logic              registrar_r;
  logic              acertou_r;
  logic              errou_r;
  logic              pronto_r;

`ifdef UC_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TIMER_W-1:0] timer_r;
  logic               timer_fim_s;
  logic               timeout_r;

  assign timer_fim_s = (timer_r == TIMER_W'(TIMEOUT - 1));
`endif

  // Next-state decision
  always_comb begin
    estado_nxt_s = INICIAL;
    case (estado_r)
      INICIAL: begin
        if (bus.iniciar) estado_nxt_s = PREPARACAO;
        else             estado_nxt_s = INICIAL;
      end
      PREPARACAO:     estado_nxt_s = NOVA_RODADA;
      NOVA_RODADA:    estado_nxt_s = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (bus.jogada)      estado_nxt_s = REGISTRA;
`ifdef UC_TIMEOUT_EN
        else if (timer_fim_s) estado_nxt_s = FIM_TIMEOUT;
`endif
        else                 estado_nxt_s = ESPERA_JOGADA;
      end
      REGISTRA:       estado_nxt_s = COMPARA;
      // endereco only advances while below rodada, rodada only while below limite_r
      COMPARA: begin
        if (!bus.igual)                  estado_nxt_s = FIM_ERRO;
        else if (endereco_r != rodada_r) estado_nxt_s = PROXIMA_JOGADA;
        else if (rodada_r == limite_r)   estado_nxt_s = FIM_ACERTOS;
        else                             estado_nxt_s = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: estado_nxt_s = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_nxt_s = NOVA_RODADA;
      FIM_ACERTOS, FIM_ERRO: begin
        if (bus.iniciar) estado_nxt_s = PREPARACAO;
        else             estado_nxt_s = estado_r;
      end
`ifdef UC_TIMEOUT_EN
      FIM_TIMEOUT: begin
        if (bus.iniciar) estado_nxt_s = PREPARACAO;
        else             estado_nxt_s = FIM_TIMEOUT;
      end
`endif
      default:        estado_nxt_s = INICIAL;
    endcase
  end

  // State register, counters and Moore outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r    <= INICIAL;
      endereco_r  <= ZERO_A;
      rodada_r    <= ZERO_A;
      limite_r    <= ZERO_A;
      zerar_r     <= 1'b1;
      registrar_r <= 1'b0;
      acertou_r   <= 1'b0;
      errou_r     <= 1'b0;
      pronto_r    <= 1'b0;
    end else begin
      estado_r <= estado_nxt_s;
      case (estado_r)
        PREPARACAO: begin
          endereco_r <= ZERO_A;
          rodada_r   <= ZERO_A;
          limite_r   <= bus.limite;
        end
        NOVA_RODADA:    endereco_r <= ZERO_A;
        PROXIMA_JOGADA: endereco_r <= endereco_r + UM_A;
        PROXIMA_RODADA: rodada_r   <= rodada_r + UM_A;
        default: begin
          endereco_r <= endereco_r;
          rodada_r   <= rodada_r;
        end
      endcase
      zerar_r     <= (estado_nxt_s == INICIAL) || (estado_nxt_s == PREPARACAO);
      registrar_r <= (estado_nxt_s == REGISTRA);
      acertou_r   <= (estado_nxt_s == FIM_ACERTOS);
      errou_r     <= (estado_nxt_s == FIM_ERRO);
`ifdef UC_TIMEOUT_EN
      pronto_r    <= (estado_nxt_s == FIM_ACERTOS) || (estado_nxt_s == FIM_ERRO) ||
                     (estado_nxt_s == FIM_TIMEOUT);
`else
      pronto_r    <= (estado_nxt_s == FIM_ACERTOS) || (estado_nxt_s == FIM_ERRO);
`endif
    end
  end

`ifdef UC_TIMEOUT_EN
  // Play timer: counts only while staying in espera_jogada, cleared on any exit
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_r   <= {TIMER_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if ((estado_r == ESPERA_JOGADA) && (estado_nxt_s == ESPERA_JOGADA)) begin
        timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
        timer_r <= {TIMER_W{1'b0}};
      end
      timeout_r <= (estado_nxt_s == FIM_TIMEOUT);
    end
  end

  assign bus.timeout = timeout_r;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.endereco  = endereco_r;
  assign bus.rodada    = rodada_r;
  assign bus.zeraR     = zerar_r;
  assign bus.registraR = registrar_r;
  assign bus.acertou   = acertou_r;
  assign bus.errou     = errou_r;
  assign bus.pronto    = pronto_r;
  assign bus.db_estado = estado_r;

endmodule

// File: tb/tb_jogo_unidade_controle_rodadas.sv
// Self-checking bench for jogo_unidade_controle_rodadas: vector table, hand sequences, random games.
module tb_jogo_unidade_controle_rodadas;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  jogo_unidade_controle_rodadas_if #(.ADDR_W(ADDR_W)) bus ();

  jogo_unidade_controle_rodadas #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int limite;
    int fail_r;
    int fail_a;
    int exp_ac;
    int exp_er;
    int exp_end;
    int exp_rod;
    int exp_db;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int code, input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (int'(bus.db_estado) == code) ok = 1'b1;
      else @(negedge clock);
    end
    if (!ok) chk(name, int'(bus.db_estado), code);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_db"},        int'(bus.db_estado), 0);
    chk({tag, "_endereco"},  int'(bus.endereco), 0);
    chk({tag, "_rodada"},    int'(bus.rodada), 0);
    chk({tag, "_zeraR"},     int'(bus.zeraR), 1);
    chk({tag, "_registraR"}, int'(bus.registraR), 0);
    chk({tag, "_acertou"},   int'(bus.acertou), 0);
    chk({tag, "_errou"},     int'(bus.errou), 0);
    chk({tag, "_timeout"},   int'(bus.timeout), 0);
    chk({tag, "_pronto"},    int'(bus.pronto), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start(input int lim);
    bus.limite  = ADDR_W'(lim);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    chk("start_preparacao", int'(bus.db_estado), 1);
  endtask

  // One play: wait for espera_jogada, strobe jogada, end on the compara cycle
  task automatic play(input int r, input int a, input bit ig, input int delay, output bit ok);
    wait_state(4, 40, "wait_espera", ok);
    if (ok) begin
      chk("play_endereco", int'(bus.endereco), a);
      chk("play_rodada", int'(bus.rodada), r);
      for (int d = 0; d < delay; d++) @(negedge clock);
      bus.jogada = 1'b1;
      bus.igual  = ig;
      @(negedge clock);
      bus.jogada = 1'b0;
      chk("registra_state", int'(bus.db_estado), 5);
      chk("registraR_on", int'(bus.registraR), 1);
      @(negedge clock);
      chk("compara_state", int'(bus.db_estado), 6);
      chk("registraR_off", int'(bus.registraR), 0);
    end
  endtask

  task automatic run_game(input int lim, input int fr, input int fa, input bit rnd_delay,
                          input int ex_ac, input int ex_er, input int ex_end, input int ex_rod,
                          input int ex_db);
    bit stop;
    bit ok;
    bit ig;
    start(lim);
    @(negedge clock);
    bus.limite = ADDR_W'(lim + 7);
    stop = 1'b0;
    for (int r = 0; r <= lim && !stop; r++) begin
      for (int a = 0; a <= r && !stop; a++) begin
        ig = !(r == fr && a == fa);
        play(r, a, ig, rnd_delay ? int'($urandom_range(0, 3)) : 0, ok);
        if (!ok || !ig) stop = 1'b1;
      end
    end
    @(negedge clock);
    chk("end_db", int'(bus.db_estado), ex_db);
    chk("end_acertou", int'(bus.acertou), ex_ac);
    chk("end_errou", int'(bus.errou), ex_er);
    chk("end_pronto", int'(bus.pronto), 1);
    chk("end_timeout", int'(bus.timeout), 0);
    chk("end_endereco", int'(bus.endereco), ex_end);
    chk("end_rodada", int'(bus.rodada), ex_rod);
  endtask

  // Game outcome from the rules: first wrong play ends it there, otherwise last play of round limite
  function automatic void model(input int lim, input int fr, input int fa,
                                output int ac, output int er, output int e, output int rd,
                                output int db);
    if (fr < 0) begin
      ac = 1; er = 0; e = lim; rd = lim; db = 12;
    end else begin
      ac = 0; er = 1; e = fa; rd = fr; db = 14;
    end
  endfunction

  initial begin
    bit ok;
    bit moved;
    int lim, fr, fa, ac, er, e, rd, db;

    vecs[0] = '{2, -1, -1, 1, 0, 2, 2, 12};
    vecs[1] = '{3, 1, 1, 0, 1, 1, 1, 14};
    vecs[2] = '{0, -1, -1, 1, 0, 0, 0, 12};
    vecs[3] = '{0, 0, 0, 0, 1, 0, 0, 14};
    vecs[4] = '{15, -1, -1, 1, 0, 15, 15, 12};
    vecs[5] = '{5, 5, 3, 0, 1, 3, 5, 14};

    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    bus.limite  = '0;
    @(negedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    bus.jogada = 1'b1;
    @(negedge clock);
    bus.jogada = 1'b0;
    @(negedge clock);
    chk("inicial_ignores_jogada", int'(bus.db_estado), 0);

    for (int i = 0; i < 6; i++) begin
      run_game(vecs[i].limite, vecs[i].fail_r, vecs[i].fail_a, 1'b0, vecs[i].exp_ac,
               vecs[i].exp_er, vecs[i].exp_end, vecs[i].exp_rod, vecs[i].exp_db);
    end

    // Error game then direct restart from fim_erro
    run_game(3, 1, 1, 1'b0, 0, 1, 1, 1, 14);
    start(3);
    @(negedge clock);
    chk("restart_nova_rodada", int'(bus.db_estado), 2);
    chk("restart_endereco", int'(bus.endereco), 0);
    chk("restart_rodada", int'(bus.rodada), 0);
    do_reset();

    // jogada pulses in fim_acertos are ignored
    run_game(0, -1, -1, 1'b0, 1, 0, 0, 0, 12);
    bus.jogada = 1'b1;
    @(negedge clock);
    bus.jogada = 1'b0;
    chk("fim_jogada_state", int'(bus.db_estado), 12);
    chk("fim_jogada_registraR", int'(bus.registraR), 0);
    @(negedge clock);
    chk("fim_jogada_hold", int'(bus.db_estado), 12);
    chk("fim_jogada_acertou", int'(bus.acertou), 1);

    // Reset while in compara during round 2
    start(3);
    ok = 1'b1;
    for (int r = 0; r <= 1 && ok; r++) begin
      for (int a = 0; a <= r && ok; a++) play(r, a, 1'b1, 0, ok);
    end
    play(2, 0, 1'b1, 0, ok);
    chk("pre_reset_rodada", int'(bus.rodada), 2);
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("midreset");
    reset = 1'b0;

`ifdef UC_TIMEOUT_EN
    // No jogada: fim_timeout exactly TIMEOUT cycles after entering espera_jogada
    start(1);
    wait_state(4, 20, "wait_espera_to", ok);
    for (int i = 1; i < TIMEOUT; i++) @(negedge clock);
    chk("to_last_wait", int'(bus.db_estado), 4);
    @(negedge clock);
    chk("to_state", int'(bus.db_estado), 13);
    chk("to_timeout", int'(bus.timeout), 1);
    chk("to_pronto", int'(bus.pronto), 1);
    chk("to_acertou", int'(bus.acertou), 0);
    chk("to_errou", int'(bus.errou), 0);
    // jogada on the last allowed cycle wins over the timeout
    start(1);
    wait_state(4, 20, "wait_espera_to2", ok);
    for (int i = 1; i < TIMEOUT; i++) @(negedge clock);
    bus.jogada = 1'b1;
    bus.igual  = 1'b1;
    @(negedge clock);
    bus.jogada = 1'b0;
    chk("to_jogada_wins", int'(bus.db_estado), 5);
    chk("to_jogada_no_timeout", int'(bus.timeout), 0);
    @(negedge clock);
    play(1, 0, 1'b1, 0, ok);
    play(1, 1, 1'b1, 0, ok);
    @(negedge clock);
    chk("to_game_done", int'(bus.db_estado), 12);
`else
    // Without the timer, espera_jogada waits forever
    start(1);
    wait_state(4, 20, "wait_espera_idle", ok);
    moved = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      if (bus.db_estado != 4'h4 || bus.timeout != 1'b0) moved = 1'b1;
    end
    chk("idle_state", int'(bus.db_estado), 4);
    chk("idle_timeout", int'(bus.timeout), 0);
    chk("idle_stable", int'(moved), 0);
`endif
    do_reset();

    // Random games against the outcome model
    for (int n = 0; n < 20; n++) begin
      lim = int'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) begin
        fr = -1; fa = -1;
      end else begin
        fr = int'($urandom_range(0, lim));
        fa = int'($urandom_range(0, fr));
      end
      model(lim, fr, fa, ac, er, e, rd, db);
      run_game(lim, fr, fa, 1'b1, ac, er, e, rd, db);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
